clock_time_setter: RTL

User-facing time/date entry controller for the BCD calendar clock. Captures the running clock's month/day/hour/minute digits and lets the user step through fields with one-cycle button pulses. Each field is adjusted up or down with wrap-around. On commit, the block presents a validated BCD time with a single-cycle `load` strobe that the clock counter uses to overwrite its registers, seconds cleared. While editing it holds `editing` high so the top level can gate the counter's `Enable`.

---
 rtl/clock_time_setter.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/clock_time_setter.sv
// clock_time_setter
//
// Time/date entry controller for the BCD calendar clock. On the first set
// pulse the running clock's month/day/hour/minute digits are captured. Each
// following set pulse selects the next field: month, day, hour, minute,
// then commit. While a field is selected, up/down pulses step it with BCD
// wrap-around. On commit the edited time is presented with a one-cycle
// load strobe. A cancel pulse returns to idle without loading.
//
// Optional feature macro: CLOCK_SETTER_BLINK_EN
//   defined   : blink toggles every BLINK_DIV cycles while editing and
//               restarts low on every field change
//   undefined : no blink counter; blink simply mirrors editing
//
// Ports
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   set_btn                      enter edit / next field / commit (1-cycle pulse)
//   up_btn, down_btn             step selected field up / down (1-cycle pulses)
//   cancel_btn                   abort edit without load (1-cycle pulse)
//   cur_month, cur_day1/0,
//   cur_hour1/0, cur_min1/0      running clock BCD digits (captured on entry)
//   set_month, set_day1/0,
//   set_hour1/0, set_min1/0      edited BCD digits (registered)
//   load                         one-cycle commit strobe, set_* valid that cycle
//   editing                      high in every state except idle
//   field                        0 idle/commit, 1 month, 2 day, 3 hour, 4 minute
//   blink                        blink phase for the selected field
module clock_time_setter #(
  parameter int MONTH_MAX = 4,
  parameter int DAY_MAX   = 30,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       set_btn,
  input  logic       up_btn,
  input  logic       down_btn,
  input  logic       cancel_btn,
  input  logic [3:0] cur_month,
  input  logic [3:0] cur_day1,
  input  logic [3:0] cur_day0,
  input  logic [3:0] cur_hour1,
  input  logic [3:0] cur_hour0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min0,
  output logic [3:0] set_month,
  output logic [3:0] set_day1,
  output logic [3:0] set_day0,
  output logic [3:0] set_hour1,
  output logic [3:0] set_hour0,
  output logic [3:0] set_min1,
  output logic [3:0] set_min0,
  output logic       load,
  output logic       editing,
  output logic [2:0] field,
  output logic       blink
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    E_MONTH = 3'd1,
    E_DAY   = 3'd2,
    E_HOUR  = 3'd3,
    E_MIN   = 3'd4,
    COMMIT  = 3'd5
  } state_t;

  // Field limits as BCD digit pairs. Month is a single digit, so its binary
  // value is already its BCD form.
  localparam logic [7:0] MONTH_MIN_BCD = 8'h00;
  localparam logic [7:0] MONTH_MAX_BCD = 8'(MONTH_MAX);
  localparam logic [7:0] DAY_MIN_BCD   = 8'h01;
  localparam logic [7:0] DAY_MAX_BCD   = 8'(((DAY_MAX / 10) << 4) | (DAY_MAX % 10));
  localparam logic [7:0] HOUR_MIN_BCD  = 8'h00;
  localparam logic [7:0] HOUR_MAX_BCD  = 8'h23;
  localparam logic [7:0] MIN_MIN_BCD   = 8'h00;
  localparam logic [7:0] MIN_MAX_BCD   = 8'h59;

  // One BCD step with field wrap. Valid BCD pairs order the same as their
  // decimal values, so range checks compare the packed byte directly. A value
  // that is not valid BCD or lies outside lo..hi snaps to lo (up) or hi (down).
  function automatic logic [7:0] bcd_adjust(input logic [7:0] val,
                                            input logic [7:0] lo,
                                            input logic [7:0] hi,
                                            input logic       up);
    logic       in_range;
    logic [7:0] res;
    in_range = (val[7:4] <= 4'd9) && (val[3:0] <= 4'd9) && (val >= lo) && (val <= hi);
    if (!in_range) begin
      res = up ? lo : hi;
    end else if (up) begin
      if (val == hi)                res = lo;
      else if (val[3:0] == 4'd9)    res = {val[7:4] + 4'd1, 4'd0};
      else                          res = {val[7:4], val[3:0] + 4'd1};
    end else begin
      if (val == lo)                res = hi;
      else if (val[3:0] == 4'd0)    res = {val[7:4] - 4'd1, 4'd9};
      else                          res = {val[7:4], val[3:0] - 4'd1};
    end
    return res;
  endfunction

  state_t     state_q, state_d;
  logic [3:0] set_month_q, set_month_d;
  logic [3:0] set_day1_q,  set_day1_d;
  logic [3:0] set_day0_q,  set_day0_d;
  logic [3:0] set_hour1_q, set_hour1_d;
  logic [3:0] set_hour0_q, set_hour0_d;
  logic [3:0] set_min1_q,  set_min1_d;
  logic [3:0] set_min0_q,  set_min0_d;
  logic       load_q,    load_d;
  logic       editing_q, editing_d;
  logic [2:0] field_q,   field_d;
  logic       blink_q,   blink_d;
  logic       step_en;
  logic [7:0] adj_val;

  always_comb begin
    state_d     = state_q;
    set_month_d = set_month_q;
    set_day1_d  = set_day1_q;
    set_day0_d  = set_day0_q;
    set_hour1_d = set_hour1_q;
    set_hour0_d = set_hour0_q;
    set_min1_d  = set_min1_q;
    set_min0_d  = set_min0_q;
    adj_val     = 8'h00;
    // Simultaneous up and down cancel each other out.
    step_en     = up_btn ^ down_btn;

    unique case (state_q)
      IDLE: begin
        if (set_btn) begin
          state_d     = E_MONTH;
          set_month_d = cur_month;
          set_day1_d  = cur_day1;
          set_day0_d  = cur_day0;
          set_hour1_d = cur_hour1;
          set_hour0_d = cur_hour0;
          set_min1_d  = cur_min1;
          set_min0_d  = cur_min0;
        end
      end
      E_MONTH: begin
        if (cancel_btn)   state_d = IDLE;
        else if (set_btn) state_d = E_DAY;
        else if (step_en) begin
          adj_val     = bcd_adjust({4'd0, set_month_q}, MONTH_MIN_BCD, MONTH_MAX_BCD, up_btn);
          set_month_d = adj_val[3:0];
        end
      end
      E_DAY: begin
        if (cancel_btn)   state_d = IDLE;
        else if (set_btn) state_d = E_HOUR;
        else if (step_en) begin
          adj_val                  = bcd_adjust({set_day1_q, set_day0_q}, DAY_MIN_BCD, DAY_MAX_BCD, up_btn);
          {set_day1_d, set_day0_d} = adj_val;
        end
      end
      E_HOUR: begin
        if (cancel_btn)   state_d = IDLE;
        else if (set_btn) state_d = E_MIN;
        else if (step_en) begin
          adj_val                    = bcd_adjust({set_hour1_q, set_hour0_q}, HOUR_MIN_BCD, HOUR_MAX_BCD, up_btn);
          {set_hour1_d, set_hour0_d} = adj_val;
        end
      end
      E_MIN: begin
        if (cancel_btn)   state_d = IDLE;
        else if (set_btn) state_d = COMMIT;
        else if (step_en) begin
          adj_val                  = bcd_adjust({set_min1_q, set_min0_q}, MIN_MIN_BCD, MIN_MAX_BCD, up_btn);
          {set_min1_d, set_min0_d} = adj_val;
        end
      end
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Status outputs are registered from the next state so they change on
    // the same edge as the transition.
    load_d    = (state_d == COMMIT);
    editing_d = (state_d != IDLE);
    unique case (state_d)
      E_MONTH: field_d = 3'd1;
      E_DAY:   field_d = 3'd2;
      E_HOUR:  field_d = 3'd3;
      E_MIN:   field_d = 3'd4;
      default: field_d = 3'd0;
    endcase
  end

`ifdef CLOCK_SETTER_BLINK_EN
  localparam logic [31:0] BLINK_LAST = 32'(BLINK_DIV - 1);

  logic [31:0] blink_cnt_q, blink_cnt_d;

  // Counter and phase restart on any state change so a newly selected field
  // always starts in the same phase.
  always_comb begin
    blink_cnt_d = 32'd0;
    blink_d     = 1'b0;
    if (editing_d && (state_d == state_q)) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = 32'd0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 32'd1;
        blink_d     = blink_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) blink_cnt_q <= 32'd0;
    else       blink_cnt_q <= blink_cnt_d;
  end
`else
  always_comb begin
    blink_d = editing_d;
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      set_month_q <= 4'd0;
      set_day1_q  <= 4'd0;
      set_day0_q  <= 4'd1;
      set_hour1_q <= 4'd0;
      set_hour0_q <= 4'd0;
      set_min1_q  <= 4'd0;
      set_min0_q  <= 4'd0;
      load_q      <= 1'b0;
      editing_q   <= 1'b0;
      field_q     <= 3'd0;
      blink_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      set_month_q <= set_month_d;
      set_day1_q  <= set_day1_d;
      set_day0_q  <= set_day0_d;
      set_hour1_q <= set_hour1_d;
      set_hour0_q <= set_hour0_d;
      set_min1_q  <= set_min1_d;
      set_min0_q  <= set_min0_d;
      load_q      <= load_d;
      editing_q   <= editing_d;
      field_q     <= field_d;
      blink_q     <= blink_d;
    end
  end

  assign set_month = set_month_q;
  assign set_day1  = set_day1_q;
  assign set_day0  = set_day0_q;
  assign set_hour1 = set_hour1_q;
  assign set_hour0 = set_hour0_q;
  assign set_min1  = set_min1_q;
  assign set_min0  = set_min0_q;
  assign load      = load_q;
  assign editing   = editing_q;
  assign field     = field_q;
  assign blink     = blink_q;

endmodule
